fir_xifu_offload: RTL and testbench
===================================

FIR_XIFU_OFFLOAD -- requirements
Module: fir_xifu_offload

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default fir_xifu_pkg::X_ID_WIDTH (4), which sets the XIF instruction ID width.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, the maximum number of in-flight writeback instructions (range 1..2**X_ID_WIDTH).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk_i in 1 (rising edge), rst_ni in 1 (async active-low reset).
REQ-004 Host-side ports SHALL be:
- instr_valid_i in 1; instr_ready_o out 1; instr_i in 32; rs1_val_i in 32; rs2_val_i in 32 (host instruction stream with operands).
- commit_valid_i in 1; commit_kill_i in 1 (host commit decision for the current instruction).
- wb_valid_o out 1; wb_rd_o out 5; wb_data_o out 32 (register writeback).
- illegal_o out 1 (pulse when the coprocessor rejects an instruction); busy_o out 1; err_o out 1.
REQ-005 XIF-side ports SHALL be:
- x_issue_valid_o out 1; x_issue_ready_i in 1; x_issue_instr_o out 32; x_issue_id_o out X_ID_WIDTH; x_issue_rs0_o out 32; x_issue_rs1_o out 32; x_issue_accept_i in 1; x_issue_writeback_i in 1.
- x_commit_valid_o out 1; x_commit_id_o out X_ID_WIDTH; x_commit_kill_o out 1.
- x_result_valid_i in 1; x_result_ready_o out 1; x_result_id_i in X_ID_WIDTH; x_result_data_i in 32; x_result_rd_i in 5; x_result_we_i in 1.

Function
REQ-006 The FSM SHALL have states IDLE, ISSUE and COMMIT; the reset state SHALL be IDLE.
REQ-007 instr_ready_o SHALL be 1 only in IDLE while outstanding < MAX_OUTSTANDING.
REQ-008 On an instr_valid_i&instr_ready_o handshake, the block SHALL latch instr_i, rs1_val_i, rs2_val_i and next_id, then enter ISSUE.
REQ-009 In ISSUE, x_issue_valid_o SHALL be 1, and instr, id and operands SHALL be held stable until x_issue_ready_i; the handshake cycle SHALL latch accept and writeback and move to COMMIT.
REQ-010 next_id SHALL increment on each issue handshake and wrap from 2**X_ID_WIDTH-1 to 0.
REQ-011 In COMMIT with accept=0, the block SHALL:
- drive x_commit_valid_o=1 and x_commit_kill_o=1 for exactly one cycle;
- pulse illegal_o the same cycle;
- return to IDLE, ignoring commit_valid_i.
REQ-012 In COMMIT with accept=1, the block SHALL:
- drive x_commit_valid_o=commit_valid_i and x_commit_kill_o=commit_kill_i combinationally, with x_commit_id_o equal to the latched id;
- go to IDLE in the cycle commit_valid_i=1.
REQ-013 outstanding SHALL increment when a commit with accept=1, writeback=1 and kill=0 occurs.
REQ-014 outstanding SHALL decrement on x_result_valid_i&x_result_ready_o with x_result_we_i=1.
REQ-015 A simultaneous increment and decrement SHALL leave outstanding unchanged.
REQ-016 x_result_ready_o SHALL be constant 1.
REQ-017 A result handshake with we=1 SHALL produce, in the next cycle, a one-cycle wb_valid_o=1 with the registered rd and data.
REQ-018 A result with we=0 SHALL produce no wb_valid_o and SHALL NOT decrement outstanding.
REQ-019 busy_o SHALL be 1 when the state is not IDLE or outstanding != 0.
REQ-020 Results SHALL be accepted in any order and in any state, including in the same cycle as an issue or commit.

Reset
REQ-021 Asserting rst_ni SHALL asynchronously force the following to 0, regardless of in-flight transactions:
- FSM state (IDLE);
- next_id, outstanding and all latched fields;
- x_issue_valid_o, x_commit_valid_o, wb_valid_o, illegal_o and err_o.

Configuration
REQ-022 With FIR_XIFU_OFFLOAD_CHECK_EN defined, the block SHALL keep a per-ID pending bit: set on a non-killed accepted writeback commit, cleared on the matching result with we=1.
REQ-023 With the macro defined, err_o SHALL set sticky (until reset) when any of these occur:
- a result arrives whose ID is not pending;
- a result arrives with outstanding=0;
- an issue is attempted to an ID that is still pending (the issue SHALL still proceed).
REQ-024 Without the macro, no scoreboard SHALL be instantiated and err_o SHALL be tied to 0.

Structure
REQ-025 The FSM state enum (fir_xifu_offload_state_t) and a host instruction struct (instr, rs1 value, rs2 value) SHALL be added to fir_xifu_pkg.
REQ-026 The per-ID pending scoreboard SHALL be a sub-module, fir_xifu_offload_sb, instantiated only under FIR_XIFU_OFFLOAD_CHECK_EN.

Verification
REQ-027 Accepted issue: instr 0x0000205B (XFIRDOTP), accept=1, writeback=1, commit kill=0, result id 0 rd 5 data 0x1234 -> wb_valid_o one cycle later with rd 5 and data 0x1234; outstanding returns to 0.
REQ-028 Rejected issue: accept=0 -> one cycle of x_commit_valid_o=1 with kill=1, illegal_o pulses once, and no outstanding increment.
REQ-029 Backpressure: x_issue_ready_i held low for 5 cycles -> x_issue_* stays stable and instr_ready_o stays 0.
REQ-030 Limit and wrap: 4 writeback instructions with no results -> instr_ready_o=0; one result frees a slot; 17 issues -> the ID sequence wraps from 15 to 0.
REQ-031 Simultaneous events: a commit increment and a result decrement in the same cycle -> outstanding is unchanged.
REQ-032 Check mode: a result with an unissued ID -> err_o=1 sticky; asserting rst_ni mid-ISSUE -> all outputs are 0 immediately.

Source files
------------

// File: rtl/fir_xifu_pkg.sv
// Shared types and constants for the FIR coprocessor XIF offload block.
package fir_xifu_pkg;

   localparam int X_ID_WIDTH = 4;

   localparam logic [31:0] XFIRDOTP_INSTR = 32'h0000_205B;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      COMMIT = 2'd2
   } fir_xifu_offload_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } fir_xifu_host_instr_t;

endpackage

// File: rtl/fir_xifu_offload_sb.sv
// Per-ID pending scoreboard with a sticky protocol-error flag.
// Only instantiated when FIR_XIFU_OFFLOAD_CHECK_EN is defined.
module fir_xifu_offload_sb
   import fir_xifu_pkg::*;
#(
   parameter int ID_W = fir_xifu_pkg::X_ID_WIDTH
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            set_i,
   input  logic [ID_W-1:0] set_id_i,
   input  logic            result_valid_i,
   input  logic            result_we_i,
   input  logic [ID_W-1:0] result_id_i,
   input  logic            outstanding_zero_i,
   input  logic            issue_i,
   input  logic [ID_W-1:0] issue_id_i,
   output logic            err_o
);

   localparam int NUM_IDS = 2 ** ID_W;

   logic [NUM_IDS-1:0] pending_q;
   logic               err_q;
   logic               err_event;

   assign err_event = (result_valid_i && (!pending_q[result_id_i] || outstanding_zero_i)) ||
                      (issue_i && pending_q[issue_id_i]);

   // A set in the same cycle as a clear of the same ID wins, since the new commit is newer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q <= '0;
      end else begin
         if (result_valid_i && result_we_i) begin
            pending_q[result_id_i] <= 1'b0;
         end
         if (set_i) begin
            pending_q[set_id_i] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (err_event) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;

endmodule

// File: rtl/fir_xifu_offload.sv
// Bridges a host instruction stream onto the XIF issue/commit/result channels.
// Optional ID scoreboard and err_o checking enabled by FIR_XIFU_OFFLOAD_CHECK_EN.
module fir_xifu_offload
   import fir_xifu_pkg::*;
#(
   parameter int X_ID_WIDTH      = fir_xifu_pkg::X_ID_WIDTH,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  instr_valid_i,
   output logic                  instr_ready_o,
   input  logic [31:0]           instr_i,
   input  logic [31:0]           rs1_val_i,
   input  logic [31:0]           rs2_val_i,
   input  logic                  commit_valid_i,
   input  logic                  commit_kill_i,
   output logic                  wb_valid_o,
   output logic [4:0]            wb_rd_o,
   output logic [31:0]           wb_data_o,
   output logic                  illegal_o,
   output logic                  busy_o,
   output logic                  err_o,
   output logic                  x_issue_valid_o,
   input  logic                  x_issue_ready_i,
   output logic [31:0]           x_issue_instr_o,
   output logic [X_ID_WIDTH-1:0] x_issue_id_o,
   output logic [31:0]           x_issue_rs0_o,
   output logic [31:0]           x_issue_rs1_o,
   input  logic                  x_issue_accept_i,
   input  logic                  x_issue_writeback_i,
   output logic                  x_commit_valid_o,
   output logic [X_ID_WIDTH-1:0] x_commit_id_o,
   output logic                  x_commit_kill_o,
   input  logic                  x_result_valid_i,
   output logic                  x_result_ready_o,
   input  logic [X_ID_WIDTH-1:0] x_result_id_i,
   input  logic [31:0]           x_result_data_i,
   input  logic [4:0]            x_result_rd_i,
   input  logic                  x_result_we_i
);

   localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   fir_xifu_offload_state_t state_q, state_d;
   fir_xifu_host_instr_t    instr_q;
   logic [X_ID_WIDTH-1:0]   id_q;
   logic [X_ID_WIDTH-1:0]   next_id_q;
   logic                    accept_q;
   logic                    writeback_q;
   logic [CNT_W-1:0]        outstanding_q;
   logic                    wb_valid_q;
   logic [4:0]              wb_rd_q;
   logic [31:0]             wb_data_q;

   logic host_ready;
   logic host_fire;
   logic issue_fire;
   logic commit_inc;
   logic result_dec;

   assign host_ready = (state_q == IDLE) && (outstanding_q < MAX_CNT);
   assign host_fire  = instr_valid_i && host_ready;
   assign issue_fire = x_issue_valid_o && x_issue_ready_i;
   assign commit_inc = (state_q == COMMIT) && accept_q && writeback_q &&
                       commit_valid_i && !commit_kill_i;
   assign result_dec = x_result_valid_i && x_result_we_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A rejected instruction is killed on the XIF side without waiting for the host.
   always_comb begin
      state_d          = state_q;
      x_issue_valid_o  = 1'b0;
      x_commit_valid_o = 1'b0;
      x_commit_kill_o  = 1'b0;
      illegal_o        = 1'b0;
      case (state_q)
         IDLE: begin
            if (host_fire) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            x_issue_valid_o = 1'b1;
            if (x_issue_ready_i) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            if (!accept_q) begin
               x_commit_valid_o = 1'b1;
               x_commit_kill_o  = 1'b1;
               illegal_o        = 1'b1;
               state_d          = IDLE;
            end else begin
               x_commit_valid_o = commit_valid_i;
               x_commit_kill_o  = commit_kill_i;
               if (commit_valid_i) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         instr_q     <= '0;
         id_q        <= '0;
         next_id_q   <= '0;
         accept_q    <= 1'b0;
         writeback_q <= 1'b0;
      end else begin
         if (host_fire) begin
            instr_q.instr <= instr_i;
            instr_q.rs1   <= rs1_val_i;
            instr_q.rs2   <= rs2_val_i;
            id_q          <= next_id_q;
         end
         if (issue_fire) begin
            accept_q    <= x_issue_accept_i;
            writeback_q <= x_issue_writeback_i;
            next_id_q   <= next_id_q + 1'b1;
         end
      end
   end

   // Saturate at zero so a stray result cannot wrap the counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
      end else begin
         case ({commit_inc, result_dec})
            2'b10:   outstanding_q <= outstanding_q + 1'b1;
            2'b01:   if (outstanding_q != '0) outstanding_q <= outstanding_q - 1'b1;
            default: outstanding_q <= outstanding_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
      end else begin
         wb_valid_q <= result_dec;
         if (result_dec) begin
            wb_rd_q   <= x_result_rd_i;
            wb_data_q <= x_result_data_i;
         end
      end
   end

   assign instr_ready_o    = host_ready;
   assign x_issue_instr_o  = instr_q.instr;
   assign x_issue_rs0_o    = instr_q.rs1;
   assign x_issue_rs1_o    = instr_q.rs2;
   assign x_issue_id_o     = id_q;
   assign x_commit_id_o    = id_q;
   assign x_result_ready_o = 1'b1;
   assign wb_valid_o       = wb_valid_q;
   assign wb_rd_o          = wb_rd_q;
   assign wb_data_o        = wb_data_q;
   assign busy_o           = (state_q != IDLE) || (outstanding_q != '0);

`ifdef FIR_XIFU_OFFLOAD_CHECK_EN
   fir_xifu_offload_sb #(
      .ID_W (X_ID_WIDTH)
   ) u_sb (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .set_i              (commit_inc),
      .set_id_i           (id_q),
      .result_valid_i     (x_result_valid_i),
      .result_we_i        (x_result_we_i),
      .result_id_i        (x_result_id_i),
      .outstanding_zero_i (outstanding_q == '0),
      .issue_i            (issue_fire),
      .issue_id_i         (id_q),
      .err_o              (err_o)
   );
`else
   logic unused_result_id;
   assign unused_result_id = ^x_result_id_i;
   assign err_o            = 1'b0;
`endif

endmodule

// File: tb/tb_fir_xifu_offload.sv
// Directed self-checking bench for fir_xifu_offload; err_o expectations follow
// FIR_XIFU_OFFLOAD_CHECK_EN.
module tb_fir_xifu_offload;
   import fir_xifu_pkg::*;

`ifdef FIR_XIFU_OFFLOAD_CHECK_EN
   localparam logic [31:0] ERR_EXP = 32'd1;
`else
   localparam logic [31:0] ERR_EXP = 32'd0;
`endif

   logic        clk_i;
   logic        rst_ni;
   logic        instr_valid_i;
   logic        instr_ready_o;
   logic [31:0] instr_i;
   logic [31:0] rs1_val_i;
   logic [31:0] rs2_val_i;
   logic        commit_valid_i;
   logic        commit_kill_i;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        illegal_o;
   logic        busy_o;
   logic        err_o;
   logic        x_issue_valid_o;
   logic        x_issue_ready_i;
   logic [31:0] x_issue_instr_o;
   logic [3:0]  x_issue_id_o;
   logic [31:0] x_issue_rs0_o;
   logic [31:0] x_issue_rs1_o;
   logic        x_issue_accept_i;
   logic        x_issue_writeback_i;
   logic        x_commit_valid_o;
   logic [3:0]  x_commit_id_o;
   logic        x_commit_kill_o;
   logic        x_result_valid_i;
   logic        x_result_ready_o;
   logic [3:0]  x_result_id_i;
   logic [31:0] x_result_data_i;
   logic [4:0]  x_result_rd_i;
   logic        x_result_we_i;

   int n_asserts = 0;
   int n_fail    = 0;
   logic [3:0] exp_id;

   fir_xifu_offload #(
      .X_ID_WIDTH      (4),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .instr_valid_i       (instr_valid_i),
      .instr_ready_o       (instr_ready_o),
      .instr_i             (instr_i),
      .rs1_val_i           (rs1_val_i),
      .rs2_val_i           (rs2_val_i),
      .commit_valid_i      (commit_valid_i),
      .commit_kill_i       (commit_kill_i),
      .wb_valid_o          (wb_valid_o),
      .wb_rd_o             (wb_rd_o),
      .wb_data_o           (wb_data_o),
      .illegal_o           (illegal_o),
      .busy_o              (busy_o),
      .err_o               (err_o),
      .x_issue_valid_o     (x_issue_valid_o),
      .x_issue_ready_i     (x_issue_ready_i),
      .x_issue_instr_o     (x_issue_instr_o),
      .x_issue_id_o        (x_issue_id_o),
      .x_issue_rs0_o       (x_issue_rs0_o),
      .x_issue_rs1_o       (x_issue_rs1_o),
      .x_issue_accept_i    (x_issue_accept_i),
      .x_issue_writeback_i (x_issue_writeback_i),
      .x_commit_valid_o    (x_commit_valid_o),
      .x_commit_id_o       (x_commit_id_o),
      .x_commit_kill_o     (x_commit_kill_o),
      .x_result_valid_i    (x_result_valid_i),
      .x_result_ready_o    (x_result_ready_o),
      .x_result_id_i       (x_result_id_i),
      .x_result_data_i     (x_result_data_i),
      .x_result_rd_i       (x_result_rd_i),
      .x_result_we_i       (x_result_we_i)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Present an instruction and hold it until accepted; returns one tick into ISSUE.
   task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
      int n;
      instr_valid_i = 1'b1;
      instr_i       = instr;
      rs1_val_i     = rs1;
      rs2_val_i     = rs2;
      #1;
      n = 0;
      while (!instr_ready_o && n < 20) begin
         step();
         n++;
      end
      if (n == 20) begin
         n_asserts++;
         n_fail++;
         $error("[TB] FAIL host_ready_timeout: observed 0, expected 1");
      end
      step();
      instr_valid_i = 1'b0;
   endtask

   task automatic xif_issue(input logic accept, input logic wb);
      x_issue_ready_i     = 1'b1;
      x_issue_accept_i    = accept;
      x_issue_writeback_i = wb;
      step();
      x_issue_ready_i     = 1'b0;
      x_issue_accept_i    = 1'b0;
      x_issue_writeback_i = 1'b0;
   endtask

   task automatic host_commit(input logic kill);
      commit_valid_i = 1'b1;
      commit_kill_i  = kill;
      step();
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
   endtask

   task automatic send_result(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] data, input logic we);
      x_result_valid_i = 1'b1;
      x_result_id_i    = id;
      x_result_rd_i    = rd;
      x_result_data_i  = data;
      x_result_we_i    = we;
      step();
      x_result_valid_i = 1'b0;
      x_result_we_i    = 1'b0;
   endtask

   // Full accepted writeback round trip up to the commit; leaves one more outstanding.
   task automatic issue_wb(input logic [31:0] instr);
      apply_stimulus(instr, 32'h0, 32'h0);
      check_output("wb_issue_id", x_issue_id_o, exp_id);
      xif_issue(1'b1, 1'b1);
      host_commit(1'b0);
      exp_id = exp_id + 1'b1;
   endtask

   initial begin
      rst_ni              = 1'b0;
      instr_valid_i       = 1'b0;
      instr_i             = '0;
      rs1_val_i           = '0;
      rs2_val_i           = '0;
      commit_valid_i      = 1'b0;
      commit_kill_i       = 1'b0;
      x_issue_ready_i     = 1'b0;
      x_issue_accept_i    = 1'b0;
      x_issue_writeback_i = 1'b0;
      x_result_valid_i    = 1'b0;
      x_result_id_i       = '0;
      x_result_data_i     = '0;
      x_result_rd_i       = '0;
      x_result_we_i       = 1'b0;
      exp_id              = 4'd0;

      // Reset state
      #1;
      check_output("rst_issue_valid", x_issue_valid_o, 0);
      check_output("rst_commit_valid", x_commit_valid_o, 0);
      check_output("rst_wb_valid", wb_valid_o, 0);
      check_output("rst_illegal", illegal_o, 0);
      check_output("rst_err", err_o, 0);
      check_output("rst_busy", busy_o, 0);
      step();
      step();
      rst_ni = 1'b1;
      step();
      check_output("idle_instr_ready", instr_ready_o, 1);
      check_output("result_ready", x_result_ready_o, 1);

      // Accepted XFIRDOTP with writeback
      $display("[TB] accepted issue");
      apply_stimulus(XFIRDOTP_INSTR, 32'h11, 32'h22);
      check_output("acc_issue_valid", x_issue_valid_o, 1);
      check_output("acc_issue_instr", x_issue_instr_o, 32'h0000205B);
      check_output("acc_issue_id", x_issue_id_o, 0);
      check_output("acc_issue_rs0", x_issue_rs0_o, 32'h11);
      check_output("acc_issue_rs1", x_issue_rs1_o, 32'h22);
      check_output("acc_instr_ready", instr_ready_o, 0);
      check_output("acc_busy", busy_o, 1);
      xif_issue(1'b1, 1'b1);
      check_output("acc_commit_idle", x_commit_valid_o, 0);
      commit_valid_i = 1'b1;
      #1;
      check_output("acc_commit_valid", x_commit_valid_o, 1);
      check_output("acc_commit_kill", x_commit_kill_o, 0);
      check_output("acc_commit_id", x_commit_id_o, 0);
      step();
      commit_valid_i = 1'b0;
      check_output("acc_busy_outst", busy_o, 1);
      check_output("acc_ready_after", instr_ready_o, 1);
      send_result(4'd0, 5'd5, 32'h1234, 1'b1);
      check_output("acc_wb_valid", wb_valid_o, 1);
      check_output("acc_wb_rd", wb_rd_o, 5);
      check_output("acc_wb_data", wb_data_o, 32'h1234);
      check_output("acc_busy_done", busy_o, 0);
      step();
      check_output("acc_wb_pulse", wb_valid_o, 0);
      exp_id = 4'd1;

      // Rejected instruction
      $display("[TB] rejected issue");
      apply_stimulus(32'h0000105B, 32'h1, 32'h2);
      check_output("rej_issue_id", x_issue_id_o, 1);
      xif_issue(1'b0, 1'b1);
      check_output("rej_commit_valid", x_commit_valid_o, 1);
      check_output("rej_commit_kill", x_commit_kill_o, 1);
      check_output("rej_commit_id", x_commit_id_o, 1);
      check_output("rej_illegal", illegal_o, 1);
      step();
      check_output("rej_commit_pulse", x_commit_valid_o, 0);
      check_output("rej_illegal_pulse", illegal_o, 0);
      check_output("rej_no_outst", busy_o, 0);
      check_output("rej_ready", instr_ready_o, 1);
      exp_id = 4'd2;

      // Backpressure on the issue channel
      $display("[TB] backpressure");
      apply_stimulus(32'hCAFE_205B, 32'hAAAA_0001, 32'hBBBB_0002);
      rs1_val_i = 32'hDEAD_BEEF;
      instr_i   = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         check_output("bp_issue_valid", x_issue_valid_o, 1);
         check_output("bp_issue_instr", x_issue_instr_o, 32'hCAFE_205B);
         check_output("bp_issue_id", x_issue_id_o, 2);
         check_output("bp_issue_rs0", x_issue_rs0_o, 32'hAAAA_0001);
         check_output("bp_issue_rs1", x_issue_rs1_o, 32'hBBBB_0002);
         check_output("bp_instr_ready", instr_ready_o, 0);
         step();
      end
      xif_issue(1'b1, 1'b0);
      host_commit(1'b0);
      check_output("bp_no_outst", busy_o, 0);
      exp_id = 4'd3;

      // Outstanding limit, then drain
      $display("[TB] outstanding limit");
      for (int i = 0; i < 4; i++) begin
         issue_wb(32'h0000205B);
      end
      check_output("lim_ready_full", instr_ready_o, 0);
      check_output("lim_busy_full", busy_o, 1);
      send_result(4'd3, 5'd1, 32'h3, 1'b1);
      check_output("lim_ready_freed", instr_ready_o, 1);
      send_result(4'd4, 5'd2, 32'h4, 1'b1);
      send_result(4'd5, 5'd3, 32'h5, 1'b1);
      send_result(4'd6, 5'd4, 32'h6, 1'b1);
      check_output("lim_drained", busy_o, 0);

      // ID wrap from 15 back to 0
      $display("[TB] id wrap");
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(32'h0000105B, 32'h0, 32'h0);
         check_output("wrap_issue_id", x_issue_id_o, exp_id);
         xif_issue(1'b0, 1'b0);
         step();
         exp_id = exp_id + 1'b1;
      end
      check_output("wrap_model_id", exp_id, 1);

      // Simultaneous increment and decrement, plus a we=0 result
      $display("[TB] simultaneous events");
      issue_wb(32'h0000205B);
      apply_stimulus(32'h0000205B, 32'h0, 32'h0);
      check_output("sim_issue_id", x_issue_id_o, 2);
      xif_issue(1'b1, 1'b1);
      commit_valid_i   = 1'b1;
      x_result_valid_i = 1'b1;
      x_result_id_i    = 4'd1;
      x_result_rd_i    = 5'd9;
      x_result_data_i  = 32'h9999;
      x_result_we_i    = 1'b1;
      step();
      commit_valid_i   = 1'b0;
      x_result_valid_i = 1'b0;
      x_result_we_i    = 1'b0;
      check_output("sim_wb_valid", wb_valid_o, 1);
      check_output("sim_wb_rd", wb_rd_o, 9);
      check_output("sim_busy_one", busy_o, 1);
      send_result(4'd2, 5'd7, 32'h7777, 1'b0);
      check_output("nowe_wb_valid", wb_valid_o, 0);
      check_output("nowe_wb_rd_hold", wb_rd_o, 9);
      check_output("nowe_busy", busy_o, 1);
      send_result(4'd2, 5'd7, 32'h7777, 1'b1);
      check_output("sim_wb_data", wb_data_o, 32'h7777);
      check_output("sim_busy_zero", busy_o, 0);
      check_output("sim_err_clean", err_o, 0);
      exp_id = 4'd3;

      // Unissued-ID result, then asynchronous reset mid-ISSUE
      $display("[TB] check mode and async reset");
      send_result(4'd9, 5'd1, 32'h1, 1'b1);
      step();
      check_output("chk_err_set", err_o, ERR_EXP);
      step();
      check_output("chk_err_sticky", err_o, ERR_EXP);
      apply_stimulus(32'h0000205B, 32'h55, 32'h66);
      check_output("mid_issue_valid", x_issue_valid_o, 1);
      #2;
      rst_ni = 1'b0;
      #1;
      check_output("arst_issue_valid", x_issue_valid_o, 0);
      check_output("arst_issue_instr", x_issue_instr_o, 0);
      check_output("arst_issue_rs0", x_issue_rs0_o, 0);
      check_output("arst_commit_valid", x_commit_valid_o, 0);
      check_output("arst_wb_valid", wb_valid_o, 0);
      check_output("arst_illegal", illegal_o, 0);
      check_output("arst_err", err_o, 0);
      check_output("arst_busy", busy_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();
      apply_stimulus(32'h0000205B, 32'h0, 32'h0);
      check_output("arst_next_id", x_issue_id_o, 0);
      xif_issue(1'b0, 1'b0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
